// File: rtl/grf_pkg.sv
// Shared widths and the queued-write entry type for the GRF write-port arbiter.
package grf_pkg;

   localparam int                REG_W    = 5;
   localparam int                DATA_W   = 32;
   localparam logic [REG_W-1:0]  ZERO_REG = '0;

   typedef struct packed {
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] data;
      logic [DATA_W-1:0] pc;
      logic              kill;
   } wq_entry_t;

endpackage

// File: rtl/grf_wq_fifo.sv
// Circular buffer of pending secondary GRF writes, with per-entry kill bit
// and combinational destination-match outputs for two query registers.
module grf_wq_fifo
   import grf_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  wq_entry_t        push_entry,
   input  logic             pop,
   input  logic             kill_en,
   input  logic [REG_W-1:0] kill_reg,
   input  logic [REG_W-1:0] query1,
   input  logic [REG_W-1:0] query2,
   output wq_entry_t        head,
   output logic [CNT_W-1:0] count,
   output logic             hit1,
   output logic             hit2
);

   wq_entry_t        mem [DEPTH];
   logic [DEPTH-1:0] valid;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   // NOTE: entry storage has no reset; the valid bits alone decide what is live.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (kill_en && valid[i] && (mem[i].rd == kill_reg)) mem[i].kill <= 1'b1;
      end
      if (push) mem[wr_ptr] <= push_entry;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (pop) begin
            valid[rd_ptr] <= 1'b0;
            rd_ptr        <= PTR_W'(rd_ptr + 1'b1);
         end
         if (push) begin
            valid[wr_ptr] <= 1'b1;
            wr_ptr        <= PTR_W'(wr_ptr + 1'b1);
         end
         case ({push, pop})
            2'b10:   count <= CNT_W'(count + 1'b1);
            2'b01:   count <= CNT_W'(count - 1'b1);
            default: count <= count;
         endcase
      end
   end

   assign head = mem[rd_ptr];

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid[i] && (mem[i].rd == query1)) hit1 = 1'b1;
         if (valid[i] && (mem[i].rd == query2)) hit2 = 1'b1;
      end
   end

endmodule

// File: rtl/grf_wport_arbiter.sv
// Shares the GRF write port between the W stage (priority) and a queued secondary source.
// Optional: define GRF_WPORT_BYPASS_EN to let a secondary result write straight through an idle, empty port.
module grf_wport_arbiter
   import grf_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              w_regwrite,
   input  logic [REG_W-1:0]  w_reg,
   input  logic [DATA_W-1:0] w_data,
   input  logic [DATA_W-1:0] w_pc,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [REG_W-1:0]  s_reg,
   input  logic [DATA_W-1:0] s_data,
   input  logic [DATA_W-1:0] s_pc,
   input  logic [REG_W-1:0]  read_reg1,
   input  logic [REG_W-1:0]  read_reg2,
   output logic              busy1,
   output logic              busy2,
   output logic              regwrite,
   output logic [REG_W-1:0]  write_reg,
   output logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] pc_new,
   output logic [CNT_W-1:0]  fifo_count
);

   wq_entry_t head;
   wq_entry_t push_entry;
   logic      w_claim;
   logic      head_valid;
   logic      s_accept;
   logic      bypass;
   logic      push;
   logic      pop;
   logic      hit1;
   logic      hit2;

   // Writes to $0 never claim the port, leaving it free for the queue head.
   assign w_claim    = !reset && w_regwrite && (w_reg != ZERO_REG);
   assign head_valid = (fifo_count != '0);
   assign s_ready    = !reset && (fifo_count < CNT_W'(DEPTH));
   assign s_accept   = s_valid && s_ready;
   assign pop        = !reset && !w_claim && head_valid;

`ifdef GRF_WPORT_BYPASS_EN
   assign bypass = s_accept && !w_claim && !head_valid && (s_reg != ZERO_REG);
`else
   assign bypass = 1'b0;
`endif

   assign push       = s_accept && (s_reg != ZERO_REG) && !bypass;
   assign push_entry = '{rd: s_reg, data: s_data, pc: s_pc, kill: 1'b0};

   grf_wq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .kill_en    (w_claim),
      .kill_reg   (w_reg),
      .query1     (read_reg1),
      .query2     (read_reg2),
      .head       (head),
      .count      (fifo_count),
      .hit1       (hit1),
      .hit2       (hit2)
   );

   // A killed head still pops, but spends its port cycle without writing.
   always_comb begin
      regwrite   = 1'b0;
      write_reg  = ZERO_REG;
      write_data = '0;
      pc_new     = '0;
      if (w_claim) begin
         regwrite   = 1'b1;
         write_reg  = w_reg;
         write_data = w_data;
         pc_new     = w_pc;
      end else if (pop) begin
         if (!head.kill) begin
            regwrite   = 1'b1;
            write_reg  = head.rd;
            write_data = head.data;
            pc_new     = head.pc;
         end
      end else if (bypass) begin
         regwrite   = 1'b1;
         write_reg  = s_reg;
         write_data = s_data;
         pc_new     = s_pc;
      end
   end

   assign busy1 = !reset && (read_reg1 != ZERO_REG) && hit1;
   assign busy2 = !reset && (read_reg2 != ZERO_REG) && hit2;

endmodule

// File: tb/tb_grf_wport_arbiter.sv
// Directed self-checking bench for grf_wport_arbiter; follows GRF_WPORT_BYPASS_EN when defined.
module tb_grf_wport_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        w_regwrite;
   logic [4:0]  w_reg;
   logic [31:0] w_data;
   logic [31:0] w_pc;
   logic        s_valid;
   logic        s_ready;
   logic [4:0]  s_reg;
   logic [31:0] s_data;
   logic [31:0] s_pc;
   logic [4:0]  read_reg1;
   logic [4:0]  read_reg2;
   logic        busy1;
   logic        busy2;
   logic        regwrite;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic [31:0] pc_new;
   logic [1:0]  fifo_count;

   int checks = 0;
   int errors = 0;

   grf_wport_arbiter #(.DEPTH(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .w_regwrite (w_regwrite),
      .w_reg      (w_reg),
      .w_data     (w_data),
      .w_pc       (w_pc),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_reg      (s_reg),
      .s_data     (s_data),
      .s_pc       (s_pc),
      .read_reg1  (read_reg1),
      .read_reg2  (read_reg2),
      .busy1      (busy1),
      .busy2      (busy2),
      .regwrite   (regwrite),
      .write_reg  (write_reg),
      .write_data (write_data),
      .pc_new     (pc_new),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      w_regwrite = 1'b0; w_reg = 5'd0; w_data = '0; w_pc = '0;
      s_valid    = 1'b0; s_reg = 5'd0; s_data = '0; s_pc = '0;
      read_reg1  = 5'd0; read_reg2 = 5'd0;
   endtask

   task automatic drive_w(input logic [4:0] r, input logic [31:0] d);
      w_regwrite = 1'b1; w_reg = r; w_data = d; w_pc = 32'h0000_3000 + {27'd0, r};
   endtask

   task automatic drive_s(input logic [4:0] r, input logic [31:0] d);
      s_valid = 1'b1; s_reg = r; s_data = d; s_pc = 32'h0000_4000 + {27'd0, r};
   endtask

   initial begin
      // reset holds every output low even with both sources requesting
      idle_inputs();
      reset = 1'b1;
      drive_w(5'd5, 32'h1111_1111);
      drive_s(5'd4, 32'h2222_2222);
      read_reg1 = 5'd4;
      #1;
      check("rst_regwrite", {31'd0, regwrite}, 32'd0);
      check("rst_s_ready",  {31'd0, s_ready},  32'd0);
      tick();
      check("rst_busy1",    {31'd0, busy1},    32'd0);
      tick();
      reset = 1'b0;
      idle_inputs();
      #1;
      check("rel_count",    {30'd0, fifo_count}, 32'd0);
      check("rel_s_ready",  {31'd0, s_ready},    32'd1);
      check("rel_regwrite", {31'd0, regwrite},   32'd0);

      // single secondary write through an idle port
      tick();
      drive_s(5'd3, 32'hdead_beef);
      read_reg1 = 5'd3;
      #1;
      check("t2_busy_push", {31'd0, busy1}, 32'd0);
`ifdef GRF_WPORT_BYPASS_EN
      check("t2_byp_we",    {31'd0, regwrite}, 32'd1);
      check("t2_byp_reg",   {27'd0, write_reg}, 32'd3);
      check("t2_byp_data",  write_data, 32'hdead_beef);
      tick();
      s_valid = 1'b0;
      #1;
      check("t2_byp_count", {30'd0, fifo_count}, 32'd0);
      check("t2_byp_busy",  {31'd0, busy1}, 32'd0);
`else
      check("t2_we_push",   {31'd0, regwrite}, 32'd0);
      tick();
      s_valid = 1'b0;
      #1;
      check("t2_busy",      {31'd0, busy1}, 32'd1);
      check("t2_count1",    {30'd0, fifo_count}, 32'd1);
      check("t2_we",        {31'd0, regwrite}, 32'd1);
      check("t2_reg",       {27'd0, write_reg}, 32'd3);
      check("t2_data",      write_data, 32'hdead_beef);
      check("t2_pc",        pc_new, 32'h0000_4003);
`endif
      tick();
      #1;
      check("t2_count0",    {30'd0, fifo_count}, 32'd0);
      check("t2_idle_we",   {31'd0, regwrite}, 32'd0);
      check("t2_busy_end",  {31'd0, busy1}, 32'd0);

      // W owns the port every cycle; two secondary results back up
      tick();
      drive_w(5'd5, 32'h0000_0050);
      drive_s(5'd10, 32'haaaa_0010);
      read_reg1 = 5'd10;
      read_reg2 = 5'd11;
      #1;
      check("t3_w_reg_a",   {27'd0, write_reg}, 32'd5);
      check("t3_w_data_a",  write_data, 32'h0000_0050);
      tick();
      drive_s(5'd11, 32'hbbbb_0011);
      #1;
      check("t3_count1",    {30'd0, fifo_count}, 32'd1);
      check("t3_w_reg_b",   {27'd0, write_reg}, 32'd5);
      tick();
      s_valid = 1'b0;
      #1;
      check("t3_count2",    {30'd0, fifo_count}, 32'd2);
      check("t3_full",      {31'd0, s_ready}, 32'd0);
      check("t3_w_reg_c",   {27'd0, write_reg}, 32'd5);
      check("t3_busy1",     {31'd0, busy1}, 32'd1);
      check("t3_busy2",     {31'd0, busy2}, 32'd1);
      tick();
      w_regwrite = 1'b0;
      #1;
      check("t3_bub_we",    {31'd0, regwrite}, 32'd1);
      check("t3_bub_reg",   {27'd0, write_reg}, 32'd10);
      check("t3_bub_data",  write_data, 32'haaaa_0010);
      check("t3_bub_ready", {31'd0, s_ready}, 32'd0);
      tick();
      drive_w(5'd5, 32'h0000_0051);
      drive_s(5'd12, 32'hcccc_0012);
      #1;
      check("t3_after_cnt", {30'd0, fifo_count}, 32'd1);
      check("t3_after_rdy", {31'd0, s_ready}, 32'd1);
      check("t3_busy1_off", {31'd0, busy1}, 32'd0);

      // full queue, idle W: pop happens but the push is refused that cycle
      tick();
      w_regwrite = 1'b0;
      drive_s(5'd13, 32'hdddd_0013);
      #1;
      check("t4_count2",    {30'd0, fifo_count}, 32'd2);
      check("t4_refuse",    {31'd0, s_ready}, 32'd0);
      check("t4_pop_reg",   {27'd0, write_reg}, 32'd11);
      tick();
      #1;
      check("t4_count1",    {30'd0, fifo_count}, 32'd1);
      check("t4_accept",    {31'd0, s_ready}, 32'd1);
      check("t4_pop2_reg",  {27'd0, write_reg}, 32'd12);
      tick();
      s_valid = 1'b0;
      #1;
      check("t4_pushpop",   {30'd0, fifo_count}, 32'd1);
      check("t4_last_reg",  {27'd0, write_reg}, 32'd13);
      check("t4_last_data", write_data, 32'hdddd_0013);
      tick();
      #1;
      check("t4_empty",     {30'd0, fifo_count}, 32'd0);

      // queued write to r7 overtaken by a W write to r7 (hazard the D stage must prevent)
      drive_w(5'd5, 32'h0000_0052);
      drive_s(5'd7, 32'h0000_0077);
      read_reg1 = 5'd7;
      read_reg2 = 5'd0;
      tick();
      s_valid = 1'b0;
      drive_w(5'd7, 32'h0000_0001);
      #1;
      check("t5_waw_hazard", {31'd0, busy1}, 32'd1);
      check("t5_w_reg",     {27'd0, write_reg}, 32'd7);
      check("t5_w_data",    write_data, 32'h0000_0001);
      tick();
      w_regwrite = 1'b0;
      #1;
      check("t5_kill_cnt",  {30'd0, fifo_count}, 32'd1);
      check("t5_kill_we",   {31'd0, regwrite}, 32'd0);
      tick();
      #1;
      check("t5_drained",   {30'd0, fifo_count}, 32'd0);
      check("t5_quiet_we",  {31'd0, regwrite}, 32'd0);

      // W write to $0 yields the port; secondary write to $0 is accepted, not queued
      drive_w(5'd5, 32'h0000_0053);
      drive_s(5'd9, 32'h9999_0009);
      read_reg1 = 5'd0;
      read_reg2 = 5'd9;
      tick();
      drive_w(5'd0, 32'h0000_0055);
      drive_s(5'd0, 32'h0bad_0000);
      #1;
      check("t6_we",        {31'd0, regwrite}, 32'd1);
      check("t6_reg",       {27'd0, write_reg}, 32'd9);
      check("t6_data",      write_data, 32'h9999_0009);
      check("t6_ready",     {31'd0, s_ready}, 32'd1);
      check("t6_busy_r0",   {31'd0, busy1}, 32'd0);
      check("t6_busy_r9",   {31'd0, busy2}, 32'd1);
      tick();
      idle_inputs();
      #1;
      check("t6_count",     {30'd0, fifo_count}, 32'd0);
      check("t6_idle_we",   {31'd0, regwrite}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
